// File: rtl/cpu_io_bridge.sv
// cpu_io_bridge: serial host-side endpoint for the CPU I/O ports.
//   RX: 8N1 UART bytes on rx are packed LSB byte first into 32-bit words.
//       Each complete word appears on input_reg with a one-cycle write_in_EN.
//       If the line stays idle too long between bytes, the partial word is dropped.
//   TX: each new a0 value is sent as 4 UART bytes on tx, LSB byte first.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   rx          UART receive line (already synchronised), idle high
//   a0          CPU a0 register value to report
//   input_reg   last fully received word
//   write_in_EN one-cycle strobe marking a new input_reg value
//   tx          UART transmit line, idle high
//   tx_busy     high while a 4-byte TX frame is in progress
//
// RX FSM:
//   state   | meaning
//   R_IDLE  | line idle, waiting for a start bit; runs the inter-byte timeout
//   R_START | checks the middle of the start bit to reject glitches
//   R_DATA  | samples 8 data bits, LSB first
//   R_STOP  | checks the stop bit, then commits or discards the byte
// TX FSM:
//   state   | meaning
//   T_IDLE  | compares a0 with the last value sent
//   T_START | drives the start bit
//   T_DATA  | drives 8 data bits, LSB first
//   T_STOP  | drives the stop bit, then moves to the next byte or finishes
module cpu_io_bridge #(
    parameter int CLKS_PER_BIT = 868,
    parameter int BYTE_TIMEOUT = 20000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    input  logic [31:0] a0,
    output logic [31:0] input_reg,
    output logic        write_in_EN,
    output logic        tx,
    output logic        tx_busy
);
    localparam int CNT_MAX = (CLKS_PER_BIT > BYTE_TIMEOUT) ? CLKS_PER_BIT : BYTE_TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] BIT_END     = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_BIT    = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] TIMEOUT_END = CW'(BYTE_TIMEOUT - 1);

    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_START = 2'd1;
    localparam logic [1:0] R_DATA  = 2'd2;
    localparam logic [1:0] R_STOP  = 2'd3;

    localparam logic [1:0] T_IDLE  = 2'd0;
    localparam logic [1:0] T_START = 2'd1;
    localparam logic [1:0] T_DATA  = 2'd2;
    localparam logic [1:0] T_STOP  = 2'd3;

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] idle_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic [1:0]    r_idx;
    logic [23:0]   r_word;   // bytes 0..2 of the word being assembled

    logic [1:0]    t_state;
    logic [CW-1:0] t_cnt;
    logic [2:0]    t_bit;
    logic [1:0]    t_idx;
    logic [31:0]   t_shift;
    logic [31:0]   a0_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= R_IDLE;
            r_cnt       <= '0;
            idle_cnt    <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            r_idx       <= '0;
            r_word      <= '0;
            input_reg   <= '0;
            write_in_EN <= 1'b0;
        end else begin
            write_in_EN <= 1'b0;
            case (r_state)
                R_IDLE: begin
                    if (!rx) begin
                        r_state  <= R_START;
                        r_cnt    <= '0;
                        idle_cnt <= '0;
                    end else if (r_idx != 2'd0) begin
                        // Partial word abandoned once the gap reaches BYTE_TIMEOUT.
                        if (idle_cnt == TIMEOUT_END) begin
                            r_idx    <= '0;
                            idle_cnt <= '0;
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end
                end
                R_START: begin
                    if (r_cnt == HALF_BIT) begin
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_state <= rx ? R_IDLE : R_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                R_DATA: begin
                    if (r_cnt == BIT_END) begin
                        r_cnt   <= '0;
                        r_shift <= {rx, r_shift[7:1]};
                        r_bit   <= r_bit + 1'b1;
                        if (r_bit == 3'd7) r_state <= R_STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                R_STOP: begin
                    if (r_cnt == BIT_END) begin
                        r_cnt   <= '0;
                        r_state <= R_IDLE;
                        if (rx) begin
                            r_idx <= r_idx + 1'b1;   // wraps to 0 after byte 3
                            case (r_idx)
                                2'd0: r_word[7:0]   <= r_shift;
                                2'd1: r_word[15:8]  <= r_shift;
                                2'd2: r_word[23:16] <= r_shift;
                                default: begin
                                    input_reg   <= {r_shift, r_word};
                                    write_in_EN <= 1'b1;
                                end
                            endcase
                        end else begin
                            r_idx <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // t_shift is consumed from bit 0 upward, so after each byte's 8 data bits
    // the next byte is already sitting in the low bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            t_state <= T_IDLE;
            t_cnt   <= '0;
            t_bit   <= '0;
            t_idx   <= '0;
            t_shift <= '0;
            a0_last <= '0;
            tx      <= 1'b1;
            tx_busy <= 1'b0;
        end else begin
            case (t_state)
                T_IDLE: begin
                    if (a0 != a0_last) begin
                        t_shift <= a0;
                        a0_last <= a0;
                        tx_busy <= 1'b1;
                        t_idx   <= '0;
                        t_cnt   <= '0;
                        tx      <= 1'b0;
                        t_state <= T_START;
                    end
                end
                T_START: begin
                    if (t_cnt == BIT_END) begin
                        t_cnt   <= '0;
                        t_bit   <= '0;
                        tx      <= t_shift[0];
                        t_shift <= {1'b0, t_shift[31:1]};
                        t_state <= T_DATA;
                    end else begin
                        t_cnt <= t_cnt + 1'b1;
                    end
                end
                T_DATA: begin
                    if (t_cnt == BIT_END) begin
                        t_cnt <= '0;
                        if (t_bit == 3'd7) begin
                            tx      <= 1'b1;
                            t_state <= T_STOP;
                        end else begin
                            tx      <= t_shift[0];
                            t_shift <= {1'b0, t_shift[31:1]};
                            t_bit   <= t_bit + 1'b1;
                        end
                    end else begin
                        t_cnt <= t_cnt + 1'b1;
                    end
                end
                T_STOP: begin
                    if (t_cnt == BIT_END) begin
                        t_cnt <= '0;
                        if (t_idx == 2'd3) begin
                            tx_busy <= 1'b0;
                            t_state <= T_IDLE;
                        end else begin
                            t_idx   <= t_idx + 1'b1;
                            tx      <= 1'b0;
                            t_state <= T_START;
                        end
                    end else begin
                        t_cnt <= t_cnt + 1'b1;
                    end
                end
                default: t_state <= T_IDLE;
            endcase
        end
    end

endmodule

// File: doc/cpu_io_bridge.md
Name: cpu_io_bridge

Overview:
- Serial host-side endpoint for the CPU's I/O ports; the far end of the CPU's input_reg/write_in_EN/a0 interface.
- Receives 8N1 UART bytes on rx and assembles each group of 4 bytes into a 32-bit word. Presents the word on input_reg with a one-cycle write_in_EN strobe for loading into x31.
- Watches the CPU's a0 and transmits each new value as 4 bytes on tx.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (must be >= 4).
- BYTE_TIMEOUT, 20000, idle clocks between RX bytes after which a partial word is discarded.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- rx  input  1  UART receive line, idle high (already synchronised to clk)
- a0  input  32  CPU a0 register value to report
- input_reg  output  32  last fully received word, to CPU x31
- write_in_EN  output  1  one-cycle strobe: input_reg holds a new word
- tx  output  1  UART transmit line, idle high
- tx_busy  output  1  high while a 4-byte TX frame is in progress

Behaviour:
- Reset, applied at the next rising edge and overriding everything:
  - Outputs: input_reg=0, write_in_EN=0, tx=1, tx_busy=0.
  - Internal: RX FSM=R_IDLE, byte index=0, a0_last=0, TX FSM=T_IDLE, all counters 0.
  - Reset mid-frame abandons the frame. tx returns high the cycle after reset; no partial byte resumes.
- RX FSM (R_IDLE, R_START, R_DATA, R_STOP):
  - R_IDLE: rx=0 -> R_START, bit counter cleared.
  - R_START: at count CLKS_PER_BIT/2 (integer division) resample rx. If rx=0 -> R_DATA; if rx=1 -> R_IDLE (glitch, nothing recorded).
  - R_DATA: sample every CLKS_PER_BIT clocks, 8 bits LSB first, then -> R_STOP.
  - R_STOP: sample after CLKS_PER_BIT clocks.
    - rx=1: byte valid, written into word bits [8k+7:8k] where k is the byte index; index increments.
    - rx=0: framing error; byte discarded and byte index reset to 0.
  - -> R_IDLE in either case.
- Word completion:
  - When byte 3 is valid, input_reg updates on the same clock edge as the stop-bit sample. write_in_EN is high for exactly that following cycle; index wraps to 0.
  - input_reg holds its value until the next complete word.
  - write_in_EN is never high for two consecutive cycles.
- Inter-byte timeout:
  - Idle counter counts while in R_IDLE with byte index != 0; it is cleared on a start bit.
  - On reaching BYTE_TIMEOUT, byte index resets to 0 and the partial word is discarded; no strobe is issued.
- TX FSM (T_IDLE, T_START, T_DATA, T_STOP):
  - T_IDLE: if a0 != a0_last, capture a0 into the shift word and into a0_last, set tx_busy=1, byte index=0 -> T_START.
  - Each byte: start bit (tx=0), 8 data bits LSB first, stop bit (tx=1), each bit held exactly CLKS_PER_BIT clocks. Bytes are sent LSB byte first, back-to-back with no extra idle between them.
  - After the stop bit of byte 3: tx_busy=0 -> T_IDLE. The a0 comparison resumes the next cycle.
- TX boundary rules:
  - a0 changes during a frame do not disturb it. Intermediate values are dropped; only the value present when T_IDLE is re-entered is sent.
  - a0 equal to a0_last is never sent. a0=0 after reset sends nothing.
- RX and TX are fully independent; simultaneous activity is permitted.
- Widths: all counters are sized for max(CLKS_PER_BIT, BYTE_TIMEOUT) with no overflow; the byte index is 2 bits.

Test Plan (CLKS_PER_BIT=4, BYTE_TIMEOUT=100):
- RX word: send bytes 0x78,0x56,0x34,0x12 back-to-back -> one write_in_EN pulse of 1 cycle after the 4th stop bit; input_reg=0x12345678; input_reg unchanged afterwards.
- RX framing error: send 0xAA, then 0xBB with stop bit=0, then 0x01,0x02,0x03,0x04 -> first two bytes discarded, single strobe, input_reg=0x04030201.
- RX timeout and glitch: send 0x11,0x22, idle 150 clocks, then 0xDD,0xCC,0xBB,0xAA -> input_reg=0xAABBCCDD. A 1-cycle low pulse on rx in idle -> no byte recorded.
- TX basic: a0 0 -> 0xDEADBEEF -> tx_busy rises the next cycle; tx carries bytes 0xEF,0xBE,0xAD,0xDE, 40 bits x 4 clocks = 160 clocks; tx_busy falls; no retransmit while a0 stays constant.
- TX coalescing: during a frame, set a0=0x1, then 0x2 -> after the frame ends exactly one further frame, carrying 0x00000002.
- Reset mid-operation: assert rst during RX byte 2 and during TX byte 1 -> tx=1, tx_busy=0, input_reg=0 next cycle. A subsequent clean 4-byte RX word is received correctly.
